// File: rtl/crc12_pkg.sv
// Shared constants and FSM state type for the CRC-12 frame controller.
package crc12_pkg;

    localparam int CRC_W = 12;

    // x^12 + x^10 + x^7 + x^4 + x^3 + x^2 + x + 1, with the x^12 term implicit
    localparam logic [CRC_W-1:0] CRC_POLY = 12'h49F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_APPEND = 2'd2
    } state_t;

endpackage

// File: rtl/crc12_d12.sv
// Combinational parallel CRC-12 update over one 12-bit word, D[11] shifted in first.
module crc12_d12
    import crc12_pkg::*;
(
    input  logic [CRC_W-1:0] data,
    input  logic [CRC_W-1:0] crc,
    output logic [CRC_W-1:0] newcrc
);

    // stage[k] is the register after the k most significant data bits have been shifted in
    logic [CRC_W-1:0] stage [0:CRC_W];

    assign stage[0] = crc;

    for (genvar gi = 0; gi < CRC_W; gi++) begin : g_bit
        logic fb;
        assign fb = stage[gi][CRC_W-1] ^ data[CRC_W-1-gi];
        assign stage[gi+1] = {stage[gi][CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
    end

    assign newcrc = stage[CRC_W];

endmodule

// File: rtl/crc12_frame_ctrl.sv
// CRC-12 frame controller: zero-latency word pass-through that appends (generate) or verifies (check) a CRC.
// Check mode is built only when CRC12_CHECK_EN is defined; otherwise every frame is a generate frame.
module crc12_frame_ctrl
    import crc12_pkg::*;
#(
    parameter logic [CRC_W-1:0] CRC_INIT = 12'h000,
    parameter int               LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             flush,
    input  logic [CRC_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [CRC_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             done,
    output logic             crc_err,
    output logic [CRC_W-1:0] crc,
    output logic [LEN_W-1:0] frame_len
);

    state_t           state_reg, state_next;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] crc_base;
    logic [CRC_W-1:0] crc_new;
    logic [CRC_W-1:0] crc_stat_reg;
    logic [LEN_W-1:0] len_reg;
    logic             done_reg;
    logic             mode_eff;
    logic             accept;
    logic             frame_start;
    logic             chk_end;
    logic             append_done;

`ifdef CRC12_CHECK_EN
    logic mode_reg;
    logic crc_err_reg;

    // mode is only meaningful on the opening word; later words use the latched copy
    assign mode_eff = (state_reg == ST_IDLE) ? mode : mode_reg;
    assign crc_err  = crc_err_reg;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign mode_eff    = 1'b0;
    assign crc_err     = 1'b0;
`endif

    // The opening word of a frame is folded onto the seed, not onto a stale register
    assign crc_base = (state_reg == ST_IDLE) ? CRC_INIT : crc_reg;

    crc12_d12 u_crc (
        .data   (in_data),
        .crc    (crc_base),
        .newcrc (crc_new)
    );

    always_comb begin
        state_next  = state_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = in_data;
        accept      = 1'b0;
        frame_start = 1'b0;
        chk_end     = 1'b0;
        append_done = 1'b0;

        if (rst || flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DATA: begin
                    in_ready  = out_ready;
                    out_valid = in_valid;
                    out_last  = mode_eff & in_last;
                    accept    = in_valid & out_ready;
                    if (accept) begin
                        frame_start = (state_reg == ST_IDLE);
                        state_next  = ST_DATA;
                        if (in_last) begin
                            if (mode_eff) begin
                                chk_end    = 1'b1;
                                state_next = ST_IDLE;
                            end else begin
                                state_next = ST_APPEND;
                            end
                        end
                    end
                end
                ST_APPEND: begin
                    out_valid = 1'b1;
                    out_last  = 1'b1;
                    out_data  = crc_reg;
                    if (out_ready) begin
                        append_done = 1'b1;
                        state_next  = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg      <= CRC_INIT;
            crc_stat_reg <= '0;
            len_reg      <= '0;
            done_reg     <= 1'b0;
`ifdef CRC12_CHECK_EN
            mode_reg     <= 1'b0;
            crc_err_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= chk_end | append_done;

            if (accept) begin
                crc_reg <= crc_new;
            end

            if (frame_start) begin
                len_reg      <= LEN_W'(1);
                crc_stat_reg <= '0;
`ifdef CRC12_CHECK_EN
                mode_reg     <= mode;
                crc_err_reg  <= 1'b0;
`endif
            end else if (accept && (len_reg != {LEN_W{1'b1}})) begin
                len_reg <= len_reg + 1'b1;
            end

            if (append_done) begin
                crc_stat_reg <= crc_reg;
            end

`ifdef CRC12_CHECK_EN
            // Placed after the frame-start clear so a one-word check frame still reports
            if (chk_end) begin
                crc_stat_reg <= crc_base;
                crc_err_reg  <= (in_data != crc_base);
            end
`endif
        end
    end

    assign done      = done_reg;
    assign crc       = crc_stat_reg;
    assign frame_len = len_reg;

endmodule
